// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcode encodings, default field widths and helpers for the instruction issuer.
package ctrl_pkg;
   localparam int DEF_ADDRESS_BITS = 5;
   localparam int DEF_INSTR_BITS = 3;
   localparam int DEF_COUNT_BITS = 4;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_STORE = 3'b010;
   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
   function automatic int value_width(input int instr_bits, input int address_bits);
      return instr_bits + address_bits;
   endfunction
   // Opcodes are widened so any INSTR_BITS compares without truncation aliasing.
   function automatic logic is_legal_op(input int unsigned op);
      return op == 32'(OP_LOAD) || op == 32'(OP_STORE);
   endfunction
endpackage

// File: rtl/issuer_fifo.sv
// issuer_fifo: pointer-based synchronous FIFO with full/empty flags and a combinational head read.
module issuer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
   end
   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = wr_ptr == rd_ptr;
   // Extra pointer bit distinguishes full from empty when the indices meet.
   assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
endmodule

// File: rtl/instr_issuer.sv
// instr_issuer: queues {opcode, address} requests and strobes them out as paced instruction words.
// Optional ISSUER_BURST_EN adds req_count: each legal request emits max(count,1) address-incrementing words.
module instr_issuer
   import ctrl_pkg::*;
#(
   parameter int ADDRESS_BITS = DEF_ADDRESS_BITS,
   parameter int INSTR_BITS = DEF_INSTR_BITS,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 1,
   parameter int COUNT_BITS = DEF_COUNT_BITS,
   localparam int VALUE_BITS = value_width(INSTR_BITS, ADDRESS_BITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [INSTR_BITS-1:0]   req_instr,
   input  logic [ADDRESS_BITS-1:0] req_address,
`ifdef ISSUER_BURST_EN
   input  logic [COUNT_BITS-1:0]   req_count,
`endif
   output logic                    enable,
   output logic [VALUE_BITS-1:0]   value,
   output logic                    busy,
   output logic                    err_illegal
);
`ifdef ISSUER_BURST_EN
   localparam int EW = VALUE_BITS + COUNT_BITS;
`else
   localparam int EW = VALUE_BITS;
`endif
   localparam int GW = $clog2(GAP_CYCLES + 2);
   state_t state, state_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [COUNT_BITS-1:0] idx, idx_n;
   logic [VALUE_BITS-1:0] value_n, word;
   logic [EW-1:0] wdata, head;
   logic enable_n, err_n, push, pop, full, empty, legal, last, decide, take;
   assign req_ready = !full && !rst;
   assign push = req_valid && req_ready;
   assign busy = !empty || state != IDLE;
`ifdef ISSUER_BURST_EN
   assign wdata = {req_count, req_instr, req_address};
   assign last = int'(idx) + 1 >= int'(head[EW-1:VALUE_BITS]);
`else
   assign wdata = {req_instr, req_address};
   assign last = 1'b1;
`endif
   issuer_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(wdata),
      .rdata(head), .full(full), .empty(empty)
   );
   assign legal = is_legal_op(32'(head[VALUE_BITS-1:ADDRESS_BITS]));
   assign word = {head[VALUE_BITS-1:ADDRESS_BITS], head[ADDRESS_BITS-1:0] + ADDRESS_BITS'(idx)};
   // Decision points: idle, the final gap cycle, or the strobe cycle itself when no gap is configured.
   assign decide = state == IDLE || (state == GAP && gap_cnt <= GW'(1)) || (state == ISSUE && GAP_CYCLES == 0);
   assign take = !empty && legal;
   always_comb begin
      state_n = state;
      gap_n = (state == GAP) ? gap_cnt - GW'(1) : gap_cnt;
      idx_n = idx;
      enable_n = 1'b0;
      value_n = value;
      err_n = 1'b0;
      pop = 1'b0;
      if (state == ISSUE && GAP_CYCLES != 0) begin
         state_n = GAP;
         gap_n = GW'(GAP_CYCLES);
      end else if (decide) begin
         state_n = take ? ISSUE : IDLE;
         enable_n = take;
         value_n = take ? word : value;
         err_n = !empty && !legal;
         pop = !empty && (!legal || last);
         idx_n = (take && !last) ? idx + COUNT_BITS'(1) : '0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gap_cnt <= '0;
         idx <= '0;
         enable <= 1'b0;
         value <= '0;
         err_illegal <= 1'b0;
      end else begin
         state <= state_n;
         gap_cnt <= gap_n;
         idx <= idx_n;
         enable <= enable_n;
         value <= value_n;
         err_illegal <= err_n;
      end
   end
endmodule

// File: tb/tb_instr_issuer.sv
// tb_instr_issuer: three issuers (gap 0, 1, 3) driven in parallel and checked against a schedule model.
module tb_instr_issuer;
   localparam int N = 3;
   logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0;
   logic [2:0] req_instr = '0;
   logic [4:0] req_address = '0;
`ifdef ISSUER_BURST_EN
   logic [3:0] req_count = 4'd1;
`endif
   logic ready [N];
   logic en [N];
   logic err [N];
   logic busy [N];
   logic [7:0] val [N];
   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      instr_issuer #(.GAP_CYCLES(g == 0 ? 0 : (g == 1 ? 1 : 3))) u_dut (
         .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready[g]),
         .req_instr(req_instr), .req_address(req_address),
`ifdef ISSUER_BURST_EN
         .req_count(req_count),
`endif
         .enable(en[g]), .value(val[g]), .busy(busy[g]), .err_illegal(err[g])
      );
   end

   typedef struct {int k; int acc; int pop;} ent_t;
   typedef struct {logic [2:0] op; logic [4:0] a; bit x_en; logic [7:0] x_val; bit x_err;} vec_t;
   logic [7:0] en_at [int];
   bit err_at [int];
   bit busy_at [int];
   ent_t fifo_q [$];
   int nd [N];
   logic [7:0] vlast [N];
   bit s_en [N], s_err [N], s_rdy [N];
   logic [7:0] s_val [N];
   int n_err [N];
   int cyc_n = 0, n_cmp = 0, n_bad = 0, cap_k = 0;
   bit armed = 0;
   logic [7:0] cap_v [$];
   int cap_t [$];

   function automatic int gap_of(int k);
      return k == 0 ? 0 : (k == 1 ? 1 : 3);
   endfunction
   function automatic int key(int k, int t);
      return k * 1000000 + t;
   endfunction
   function automatic int cnt_eff();
`ifdef ISSUER_BURST_EN
      return int'(req_count);
`else
      return 1;
`endif
   endfunction

   task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc_n, act, exp);
      end
   endtask

   function automatic int occ(int k, int c);
      int o = 0;
      foreach (fifo_q[j]) if (fifo_q[j].k == k && fifo_q[j].acc < c && fifo_q[j].pop >= c) o++;
      return o;
   endfunction

   // A request is decided once it reaches the head and the issuer is at a decision point.
   task automatic sched(int k, int c, logic [2:0] op, logic [4:0] a, int cnt);
      bit lg = op == 3'd1 || op == 3'd2;
      int n = lg ? (cnt < 1 ? 1 : cnt) : 1;
      int d = (c + 1 > nd[k]) ? c + 1 : nd[k];
      if (!lg) begin
         err_at[key(k, d + 1)] = 1;
         nd[k] = d + 1;
      end else begin
         for (int w = 0; w < n; w++) begin
            if (w > 0) d = nd[k];
            en_at[key(k, d + 1)] = {op, a + 5'(w)};
            for (int t = d + 1; t <= d + 1 + gap_of(k); t++) busy_at[key(k, t)] = 1;
            nd[k] = d + 1 + gap_of(k);
         end
      end
      fifo_q.push_back('{k, c, d});
   endtask

   task automatic reset_model(int c);
      int dk [$];
      foreach (en_at[i]) if (i % 1000000 > c) dk.push_back(i);
      foreach (dk[j]) en_at.delete(dk[j]);
      dk = {};
      foreach (err_at[i]) if (i % 1000000 > c) dk.push_back(i);
      foreach (dk[j]) err_at.delete(dk[j]);
      dk = {};
      foreach (busy_at[i]) if (i % 1000000 > c) dk.push_back(i);
      foreach (dk[j]) busy_at.delete(dk[j]);
      fifo_q.delete();
      for (int k = 0; k < N; k++) begin
         nd[k] = c + 1;
         vlast[k] = '0;
      end
   endtask

   task automatic cyc();
      int o;
      bit pr;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         o = occ(k, cyc_n);
         pr = !rst && o < 4;
         chk("req_ready", k, ready[k], pr);
         if (armed) begin
            if (en_at.exists(key(k, cyc_n))) vlast[k] = en_at[key(k, cyc_n)];
            chk("enable", k, en[k], en_at.exists(key(k, cyc_n)));
            chk("value", k, val[k], vlast[k]);
            chk("err_illegal", k, err[k], err_at.exists(key(k, cyc_n)));
            chk("busy", k, busy[k], o > 0 || busy_at.exists(key(k, cyc_n)));
         end
         if (pr && req_valid) sched(k, cyc_n, req_instr, req_address, cnt_eff());
         s_en[k] = en[k];
         s_val[k] = val[k];
         s_err[k] = err[k];
         s_rdy[k] = ready[k];
         if (err[k] === 1'b1) n_err[k]++;
         if (k == cap_k && en[k] === 1'b1) begin
            cap_v.push_back(val[k]);
            cap_t.push_back(cyc_n);
         end
      end
      if (rst) begin
         reset_model(cyc_n);
         armed = 1;
      end
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic clear_cap(int k);
      cap_k = k;
      cap_v = {};
      cap_t = {};
      for (int i = 0; i < N; i++) n_err[i] = 0;
   endtask

   vec_t tbl [6];
   int waited, nlow;
   initial begin
      tbl[0] = '{3'd1, 5'd7, 1'b1, 8'h27, 1'b0};
      tbl[1] = '{3'd2, 5'd2, 1'b1, 8'h42, 1'b0};
      tbl[2] = '{3'd7, 5'd1, 1'b0, 8'h42, 1'b1};
      tbl[3] = '{3'd0, 5'd0, 1'b0, 8'h42, 1'b1};
      tbl[4] = '{3'd1, 5'd31, 1'b1, 8'h3F, 1'b0};
      tbl[5] = '{3'd2, 5'd0, 1'b1, 8'h40, 1'b0};
      for (int k = 0; k < N; k++) begin
         nd[k] = 0;
         vlast[k] = '0;
      end
      req_valid = 1'b1;
      req_instr = 3'd1;
      req_address = 5'd3;
      repeat (3) cyc();
      rst = 1'b0;
      req_valid = 1'b0;
      cyc();
      chk("ready_after_rst", 1, s_rdy[1], 1'b1);
      repeat (4) cyc();

      foreach (tbl[i]) begin
         req_valid = 1'b1;
         req_instr = tbl[i].op;
         req_address = tbl[i].a;
         cyc();
         req_valid = 1'b0;
         cyc();
         cyc();
         chk("tbl_enable", 1, s_en[1], tbl[i].x_en);
         chk("tbl_value", 1, s_val[1], tbl[i].x_val);
         chk("tbl_err", 1, s_err[1], tbl[i].x_err);
         repeat (6) cyc();
      end

      clear_cap(0);
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1;
         req_instr = 3'd1;
         req_address = 5'(i);
         cyc();
      end
      req_valid = 1'b0;
      repeat (12) cyc();
      chk("b2b_count", 0, cap_v.size(), 4);
      for (int i = 0; i < 4 && i < cap_v.size(); i++) begin
         chk("b2b_value", 0, cap_v[i], 8'h20 + 8'(i));
         chk("b2b_cycle", 0, cap_t[i] - cap_t[0], i);
      end

      clear_cap(2);
      nlow = 0;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_instr = (i % 2 == 0) ? 3'd1 : 3'd2;
         req_address = 5'(i + 10);
         waited = 0;
         do begin
            cyc();
            if (!s_rdy[2]) nlow++;
            waited++;
         end while (!s_rdy[2] && waited < 60);
         if (waited >= 60) chk("full_wait_timeout", 2, waited, 0);
      end
      req_valid = 1'b0;
      repeat (40) cyc();
      chk("full_ready_dropped", 2, nlow > 0, 1'b1);
      chk("full_count", 2, cap_v.size(), 6);
      for (int i = 0; i < 6 && i < cap_v.size(); i++)
         chk("full_order", 2, cap_v[i], {((i % 2 == 0) ? 3'd1 : 3'd2), 5'(i + 10)});

      clear_cap(1);
      req_valid = 1'b1;
      req_instr = 3'd7;
      req_address = 5'd1;
      cyc();
      req_instr = 3'd2;
      req_address = 5'd2;
      cyc();
      req_valid = 1'b0;
      repeat (10) cyc();
      chk("illegal_err_pulses", 1, n_err[1], 1);
      chk("illegal_enables", 1, cap_v.size(), 1);
      if (cap_v.size() > 0) chk("illegal_next_value", 1, cap_v[0], 8'h42);

`ifdef ISSUER_BURST_EN
      clear_cap(0);
      req_valid = 1'b1;
      req_instr = 3'd1;
      req_address = 5'd30;
      req_count = 4'd4;
      cyc();
      req_valid = 1'b0;
      req_count = 4'd1;
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      repeat (8) cyc();
      chk("burst_words_before_rst", 0, cap_v.size(), 2);
      if (cap_v.size() > 1) begin
         chk("burst_w0", 0, cap_v[0], 8'h3E);
         chk("burst_w1", 0, cap_v[1], 8'h3F);
      end
      clear_cap(0);
      req_valid = 1'b1;
      req_address = 5'd30;
      req_count = 4'd4;
      cyc();
      req_valid = 1'b0;
      repeat (10) cyc();
      chk("burst_len", 0, cap_v.size(), 4);
      for (int i = 0; i < 4 && i < cap_v.size(); i++)
         chk("burst_wrap", 0, cap_v[i], {3'd1, 5'd30 + 5'(i)});
`endif

      for (int i = 0; i < 1500; i++) begin
         req_valid = 1'($urandom % 2);
         case ($urandom % 4)
            0: req_instr = 3'd1;
            1: req_instr = 3'd2;
            2: req_instr = 3'($urandom);
            default: req_instr = 3'd1;
         endcase
         req_address = 5'($urandom);
`ifdef ISSUER_BURST_EN
         req_count = 4'($urandom_range(0, 5));
`endif
         rst = ($urandom % 200) == 0;
         cyc();
      end
      rst = 1'b0;
      req_valid = 1'b0;
      repeat (60) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
